fir_bank_cas: RTL

FIR_BANK_CAS -- requirements
Module: fir_bank_cas

---
 rtl/fir_bank_cas.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fir_bank_cas.sv
// rtl/fir_bank_cas.sv - NCH-channel FIR bank sharing one input delay line, 2-cycle pipeline
//
// Ports:
//   clk, reset (async active-low)  clock and reset
//   clk_enable                     global enable; all state holds while low
//   in_valid, filter_in            input sample strobe and signed sample
//   coef_wr_en/_ch/_tap/_data      coefficient write port
//   filter_out                     channel c result in [c*DATA_W +: DATA_W]
//   out_valid                      one-cycle pulse when filter_out updates
//   sat_flag                       per-channel clamp indicator for the last output
module fir_bank_cas #(
    parameter  int NCH    = 4,
    parameter  int TAPS   = 5,
    parameter  int DATA_W = 8,
    parameter  int COEF_W = 8,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int TAP_W  = $clog2(TAPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     filter_in,
    input  logic                  coef_wr_en,
    input  logic [CH_W-1:0]       coef_wr_ch,
    input  logic [TAP_W-1:0]      coef_wr_tap,
    input  logic [COEF_W-1:0]     coef_wr_data,
    output logic [NCH*DATA_W-1:0] filter_out,
    output logic                  out_valid,
    output logic [NCH-1:0]        sat_flag
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + $clog2(TAPS);
    localparam int SHIFT  = COEF_W - 2;
    localparam logic signed [SUM_W-1:0]  RND      = SUM_W'(2 ** (COEF_W - 3));
    localparam logic signed [SUM_W-1:0]  SAT_MAX  = SUM_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [SUM_W-1:0]  SAT_MIN  = ~SAT_MAX;
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(2 ** (COEF_W - 2));

    // Reset asserts asynchronously but releases only after two clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic signed [DATA_W-1:0] x_q        [TAPS];
    logic signed [COEF_W-1:0] coef_q     [NCH][TAPS];
    // Snapshot of coef_q taken when a sample is accepted, so a write landing on
    // the same edge only reaches the following sample.
    logic signed [COEF_W-1:0] coef_act_q [NCH][TAPS];
    logic signed [PROD_W-1:0] p_q        [NCH][TAPS];
    logic signed [PROD_W-1:0] prod_d     [NCH][TAPS];
    logic                     v1_q, v2_q, out_valid_q;
    logic [NCH*DATA_W-1:0]    out_q, out_d;
    logic [NCH-1:0]           sat_q, sat_d;
    logic                     wr_ok;

    assign wr_ok = coef_wr_en && (int'(coef_wr_ch) < NCH) && (int'(coef_wr_tap) < TAPS);

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_d[c][k] = PROD_W'(x_q[k]) * PROD_W'(coef_act_q[c][k]);
            end
        end
    end

    always_comb begin : sum_sat
        logic signed [SUM_W-1:0] acc;
        logic signed [SUM_W-1:0] shifted;
        out_d   = '0;
        sat_d   = '0;
        acc     = '0;
        shifted = '0;
        for (int c = 0; c < NCH; c++) begin
            // Rounding constant is folded into the accumulator start value.
            acc = RND;
            for (int k = 0; k < TAPS; k++) begin
                acc = acc + SUM_W'(p_q[c][k]);
            end
            shifted = acc >>> SHIFT;
            if (shifted > SAT_MAX) begin
                out_d[c*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
                sat_d[c]                  = 1'b1;
            end else if (shifted < SAT_MIN) begin
                out_d[c*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
                sat_d[c]                  = 1'b1;
            end else begin
                out_d[c*DATA_W +: DATA_W] = shifted[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    coef_q[c][k]     <= (k == 0) ? COEF_ONE : '0;
                    coef_act_q[c][k] <= (k == 0) ? COEF_ONE : '0;
                    p_q[c][k]        <= '0;
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            sat_q       <= '0;
        end else if (clk_enable) begin
            if (wr_ok) begin
                coef_q[coef_wr_ch][coef_wr_tap] <= coef_wr_data;
            end
            if (in_valid) begin
                x_q[0] <= filter_in;
                for (int k = 1; k < TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
                coef_act_q <= coef_q;
            end
            v1_q <= in_valid;
            v2_q <= v1_q;
            if (v1_q) begin
                p_q <= prod_d;
            end
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_q <= out_d;
                sat_q <= sat_d;
            end
        end
    end

    assign filter_out = out_q;
    assign out_valid  = out_valid_q;
    assign sat_flag   = sat_q;

endmodule
